// File: rtl/game_pkg.sv
// Shared game geometry, car FSM state encoding and position saturation helpers.
// Imported by the motion controller and the car renderer.
package game_pkg;

  localparam int unsigned CAR_W    = 16;
  localparam int unsigned CAR_H    = 32;
  localparam int unsigned ROAD_W   = 256;
  localparam int unsigned SCREEN_H = 480;

  // X_MAX is exclusive (x + CAR_W must stay below ROAD_W); Y_MAX is the last legal row.
  localparam int unsigned X_MAX = ROAD_W - CAR_W;
  localparam int unsigned Y_MAX = SCREEN_H - CAR_H - 1;
  localparam int unsigned X_HI  = X_MAX - 1;
  localparam int unsigned Y_HI  = Y_MAX;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CRASH = 2'd2;

  function automatic logic [7:0] sat_x(input logic signed [8:0] v);
    if (v < 0) begin
      return 8'd0;
    end else if (v > $signed(9'(X_HI))) begin
      return 8'(X_HI);
    end
    return v[7:0];
  endfunction

  function automatic logic [9:0] sat_y(input logic signed [10:0] v);
    if (v < 0) begin
      return 10'd0;
    end else if (v > $signed(11'(Y_HI))) begin
      return 10'(Y_HI);
    end
    return v[9:0];
  endfunction

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchronizer for a bus of independent, slowly changing levels.
module btn_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] btn_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
    end
  end

  assign btn_o = sync_q;

endmodule

// File: rtl/car_motion_controller.sv
// Player car position integrator with idle/drive/crash FSM and road/screen clamping.
// Optional crash blink on car_visible enabled by defining CAR_CRASH_BLINK_EN.
module car_motion_controller
  import game_pkg::*;
#(
  parameter int unsigned STEP_X       = 2,
  parameter int unsigned STEP_Y       = 2,
  parameter int unsigned START_X      = 120,
  parameter int unsigned START_Y      = 400,
  parameter int unsigned CRASH_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       crash,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [7:0] car_position_x,
  output logic [9:0] car_position_y,
  output logic       car_visible,
  output logic [1:0] state_o
);

  localparam logic signed [8:0]  DX   = 9'(STEP_X);
  localparam logic signed [10:0] DY   = 11'(STEP_Y);
  localparam logic [7:0]         X0   = 8'(START_X);
  localparam logic [9:0]         Y0   = 10'(START_Y);
  localparam logic [7:0]         CNT0 = 8'(CRASH_FRAMES);

  logic [3:0] btn_raw;
  logic [3:0] btn_s;
  logic       left_s, right_s, up_s, down_s;

  logic [1:0] state_q, state_d;
  logic [7:0] x_q, x_d, x_mv;
  logic [9:0] y_q, y_d, y_mv;
  logic [7:0] cnt_q, cnt_d;

  logic signed [8:0]  x_ext;
  logic signed [10:0] y_ext;

  assign btn_raw = {btn_left, btn_right, btn_up, btn_down};

  btn_sync2 #(
    .WIDTH(4)
  ) u_btn_sync (
    .clk  (clk),
    .reset(reset),
    .btn_i(btn_raw),
    .btn_o(btn_s)
  );

  assign {left_s, right_s, up_s, down_s} = btn_s;

  assign x_ext = $signed({1'b0, x_q});
  assign y_ext = $signed({1'b0, y_q});

  // Candidate position for this frame; opposing buttons cancel.
  always_comb begin
    x_mv = x_q;
    if (left_s && !right_s) begin
      x_mv = sat_x(x_ext - DX);
    end else if (right_s && !left_s) begin
      x_mv = sat_x(x_ext + DX);
    end

    y_mv = y_q;
    if (up_s && !down_s) begin
      y_mv = sat_y(y_ext - DY);
    end else if (down_s && !up_s) begin
      y_mv = sat_y(y_ext + DY);
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        x_d   = X0;
        y_d   = Y0;
        cnt_d = 8'd0;
        if (start) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        // A crash in the same cycle as a tick suppresses that frame's motion.
        if (crash) begin
          state_d = CRASH;
          cnt_d   = CNT0;
        end else if (frame_tick) begin
          x_d = x_mv;
          y_d = y_mv;
        end
      end
      CRASH: begin
        if (frame_tick) begin
          if (cnt_q <= 8'd1) begin
            cnt_d   = 8'd0;
            x_d     = X0;
            y_d     = Y0;
            state_d = DRIVE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        x_d     = X0;
        y_d     = Y0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= X0;
      y_q     <= Y0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign car_position_x = x_q;
  assign car_position_y = y_q;
  assign state_o        = state_q;

`ifdef CAR_CRASH_BLINK_EN
  assign car_visible = (state_q == CRASH) ? cnt_q[2] : 1'b1;
`else
  assign car_visible = 1'b1;
`endif

endmodule

// File: tb/tb_car_motion_controller.sv
// Self-checking bench for car_motion_controller: vector table plus crash/reset sequences.
module tb_car_motion_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, start, crash;
  logic       btn_left, btn_right, btn_up, btn_down;
  logic [7:0] car_position_x;
  logic [9:0] car_position_y;
  logic       car_visible;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

`ifdef CAR_CRASH_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [7:0] x;
    logic [9:0] y;
    logic [1:0] s;
    logic       v;
  } exp_t;

  typedef struct {
    logic l, r, u, d, tk, st, cr;
    int   x, y, s;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[13];

  car_motion_controller dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .start         (start),
    .crash         (crash),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .car_position_x(car_position_x),
    .car_position_y(car_position_y),
    .car_visible   (car_visible),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input string n, input int x, input int y, input int s,
                              input int cnt);
    exp_t e;
    e.name = n;
    e.x    = 8'(x);
    e.y    = 10'(y);
    e.s    = 2'(s);
    e.v    = !(BLINK && (s == 2) && !cnt[2]);
    return e;
  endfunction

  task automatic check(input exp_t e);
    checks++;
    if (car_position_x !== e.x || car_position_y !== e.y || state_o !== e.s ||
        car_visible !== e.v) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d state=%0d vis=%0b, want x=%0d y=%0d state=%0d vis=%0b",
               e.name, car_position_x, car_position_y, state_o, car_visible,
               e.x, e.y, e.s, e.v);
    end
  endtask

  // Buttons settle through the synchronizer before the strobe cycle.
  task automatic step(input logic l, r, u, d, tk, st, cr, input exp_t e);
    exp_t got;
    btn_left  = l;
    btn_right = r;
    btn_up    = u;
    btn_down  = d;
    repeat (3) @(posedge clk);
    #1;
    frame_tick = tk;
    start      = st;
    crash      = cr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    start      = 1'b0;
    crash      = 1'b0;
    got = sb.pop_front();
    check(got);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    start      = 1'b0;
    crash      = 1'b0;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 120, 400, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 120, 400, 1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 122, 400, 1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 124, 400, 1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 126, 400, 1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128, 400, 1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 130, 400, 1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 130, 402, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 130, 404, 1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 130, 406, 1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 128, 404, 1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 128, 404, 1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128, 404, 1};

    repeat (2) @(posedge clk);
    #1;
    check(mk("reset", 120, 400, 0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d, tbl[i].tk, tbl[i].st, tbl[i].cr,
           mk($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].s, 0));
    end

    // Right edge saturation: 238 then 239, 239.
    for (int k = 1; k <= 57; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
           mk($sformatf("right%0d", k), (128 + 2 * k > 239) ? 239 : 128 + 2 * k, 404, 1, 0));
    end
    // Bottom saturation at 447.
    for (int k = 1; k <= 22; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
           mk($sformatf("down%0d", k), 239, (404 + 2 * k > 447) ? 447 : 404 + 2 * k, 1, 0));
    end
    // Up from 447 reaches 1, then clamps at 0.
    for (int k = 1; k <= 225; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
           mk($sformatf("up%0d", k), 239, (447 - 2 * k < 0) ? 0 : 447 - 2 * k, 1, 0));
    end

    // Crash coincident with a tick: no motion, frozen for 60 ticks, respawn.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, mk("crash_tick", 239, 0, 2, 60));
    for (int k = 1; k <= 59; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, (k == 10) ? 1'b1 : 1'b0,
           mk($sformatf("frozen%0d", k), 239, 0, 2, 60 - k));
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk("respawn", 120, 400, 1, 0));
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk("resume", 118, 402, 1, 0));

    // Crash without a tick, then asynchronous reset partway through the freeze.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk("crash2", 118, 402, 2, 60));
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
           mk($sformatf("crash2_%0d", k), 118, 402, 2, 60 - k));
    end
    #2;
    reset = 1'b1;
    #1;
    check(mk("async_reset", 120, 400, 0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // start beats crash in IDLE, then normal motion.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, mk("start_vs_crash", 120, 400, 1, 0));
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk("restart_move", 122, 400, 1, 0));
    // No tick: position must not change mid-frame.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk("no_tick_hold", 122, 400, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
